// File: rtl/iommu_rd_port_arb.sv
// IOMMU read-port arbiter: shares one AXI4 AR/R master among NumReq requesters, AXI ID = requester index.
// Define IOMMU_RD_ARB_FIXPRIO_EN for fixed-priority (lowest index wins) instead of round-robin.
package lint_wrapper;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module iommu_rd_port_arb #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned MaxOutstd = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    rq_ar_valid_i,
  output logic [NumReq-1:0]    rq_ar_ready_o,
  input  logic [NumReq*64-1:0] rq_ar_addr_i,
  input  logic [NumReq*8-1:0]  rq_ar_len_i,
  input  logic [NumReq*3-1:0]  rq_ar_size_i,
  output logic [NumReq-1:0]    rq_r_valid_o,
  input  logic [NumReq-1:0]    rq_r_ready_i,
  output logic [63:0]          rq_r_data_o,
  output logic [1:0]           rq_r_resp_o,
  output logic                 rq_r_last_o,
  output lint_wrapper::req_t   mem_req_o,
  input  lint_wrapper::resp_t  mem_resp_i,
  output logic                 busy_o,
  output logic                 err_id_o
);
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned IdW  = lint_wrapper::IdWidth;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]      r_state;
  logic [IdxW-1:0] r_win;
  logic [63:0]     r_addr;
  logic [7:0]      r_len;
  logic [2:0]      r_size;
  logic [3:0]      r_cnt [NumReq];
`ifndef IOMMU_RD_ARB_FIXPRIO_EN
  logic [IdxW-1:0] r_ptr;
`endif

  logic [NumReq-1:0] w_elig;
  logic [NumReq-1:0] w_inc;
  logic [NumReq-1:0] w_dec;
  logic              w_any;
  logic [IdxW-1:0]   w_sel;
  logic              w_map;
  logic              w_r_ready;
  logic              w_r_last_hs;
  logic              w_ar_hs;
  logic              w_dec_err;
  logic              w_cnt_nz;
  logic              w_unused;

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_elig[i] = rq_ar_valid_i[i] && (32'(r_cnt[i]) != MaxOutstd);
    end
  end

  // First eligible index scanning upward from the start point, wrapping.
  always_comb begin
    int unsigned idx;
    w_any = 1'b0;
    w_sel = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
`ifdef IOMMU_RD_ARB_FIXPRIO_EN
      idx = k;
`else
      idx = (32'(r_ptr) + k) % NumReq;
`endif
      if (!w_any && w_elig[IdxW'(idx)]) begin
        w_any = 1'b1;
        w_sel = IdxW'(idx);
      end
    end
  end

  always_comb begin
    rq_ar_ready_o = '0;
    if (r_state == IDLE && w_any) begin
      rq_ar_ready_o[w_sel] = 1'b1;
    end
  end

  // Unmapped IDs are sunk unconditionally so a stray beat cannot stall the port.
  assign w_map = 32'(mem_resp_i.r.id) < NumReq;

  always_comb begin
    rq_r_valid_o = '0;
    w_r_ready    = !w_map;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (w_map && 32'(mem_resp_i.r.id) == i) begin
        rq_r_valid_o[i] = mem_resp_i.r_valid;
        w_r_ready       = rq_r_ready_i[i];
      end
    end
  end

  assign rq_r_data_o = mem_resp_i.r.data;
  assign rq_r_resp_o = mem_resp_i.r.resp;
  assign rq_r_last_o = mem_resp_i.r.last;

  assign w_ar_hs     = (r_state == HOLD) && mem_resp_i.ar_ready;
  assign w_r_last_hs = mem_resp_i.r_valid && w_r_ready && mem_resp_i.r.last && w_map;

  always_comb begin
    w_dec_err = 1'b0;
    w_cnt_nz  = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_inc[i] = w_ar_hs && (32'(r_win) == i);
      w_dec[i] = w_r_last_hs && (32'(mem_resp_i.r.id) == i);
      if (w_dec[i] && !w_inc[i] && r_cnt[i] == '0) begin
        w_dec_err = 1'b1;
      end
      if (r_cnt[i] != '0) begin
        w_cnt_nz = 1'b1;
      end
    end
  end

  assign err_id_o = (mem_resp_i.r_valid && !w_map) || w_dec_err;
  assign busy_o   = (r_state == HOLD) || w_cnt_nz;

  always_comb begin
    mem_req_o         = '0;
    mem_req_o.b_ready = 1'b1;
    mem_req_o.r_ready = w_r_ready;
    if (r_state == HOLD) begin
      mem_req_o.ar_valid  = 1'b1;
      mem_req_o.ar.id     = IdW'(r_win);
      mem_req_o.ar.addr   = r_addr;
      mem_req_o.ar.len    = r_len;
      mem_req_o.ar.size   = r_size;
      mem_req_o.ar.burst  = 2'b01;
      mem_req_o.ar.cache  = 4'b0010;
    end
  end

  assign w_unused = ^{mem_resp_i.aw_ready, mem_resp_i.w_ready, mem_resp_i.b_valid, mem_resp_i.b};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
`ifndef IOMMU_RD_ARB_FIXPRIO_EN
      r_ptr   <= '0;
`endif
      for (int unsigned i = 0; i < NumReq; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      if (r_state == IDLE) begin
        if (w_any) begin
          r_state <= HOLD;
          r_win   <= w_sel;
          r_addr  <= rq_ar_addr_i[64*w_sel +: 64];
          r_len   <= rq_ar_len_i[8*w_sel +: 8];
          r_size  <= rq_ar_size_i[3*w_sel +: 3];
        end
      end else if (mem_resp_i.ar_ready) begin
        r_state <= IDLE;
`ifndef IOMMU_RD_ARB_FIXPRIO_EN
        r_ptr   <= (32'(r_win) + 32'd1 == NumReq) ? '0 : r_win + IdxW'(1);
`endif
      end
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end else if (w_dec[i] && !w_inc[i] && r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_iommu_rd_port_arb.sv
// Self-checking bench for iommu_rd_port_arb: directed scenarios plus random traffic vs a transaction-level model.
module tb_iommu_rd_port_arb;
  localparam int N    = 4;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    rq_ar_valid, rq_ar_ready, rq_r_valid, rq_r_ready;
  logic [N*64-1:0] rq_ar_addr;
  logic [N*8-1:0]  rq_ar_len;
  logic [N*3-1:0]  rq_ar_size;
  logic [63:0]     rq_r_data;
  logic [1:0]      rq_r_resp;
  logic            rq_r_last;
  lint_wrapper::req_t  mem_req;
  lint_wrapper::resp_t mem_resp;
  logic            busy, err_id;

  iommu_rd_port_arb #(.NumReq(N), .MaxOutstd(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .rq_ar_valid_i(rq_ar_valid), .rq_ar_ready_o(rq_ar_ready),
    .rq_ar_addr_i(rq_ar_addr), .rq_ar_len_i(rq_ar_len), .rq_ar_size_i(rq_ar_size),
    .rq_r_valid_o(rq_r_valid), .rq_r_ready_i(rq_r_ready),
    .rq_r_data_o(rq_r_data), .rq_r_resp_o(rq_r_resp), .rq_r_last_o(rq_r_last),
    .mem_req_o(mem_req), .mem_resp_i(mem_resp),
    .busy_o(busy), .err_id_o(err_id)
  );

  int checks = 0;
  int failures = 0;

  // Stimulus knobs, applied at each falling edge
  logic [N-1:0] s_valid, s_rready;
  logic [63:0]  s_addr [N];
  logic [7:0]   s_len  [N];
  logic [2:0]   s_size [N];
  logic         s_arready, s_rv, s_rlast;
  logic [3:0]   s_rid;
  logic [63:0]  s_rdata;
  logic [1:0]   s_rresp;

  // Reference model: outstanding counts, rotating start point, one pending AR record
  int          m_cnt [N];
  int          m_ptr;
  bit          m_pend;
  int          m_w;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  int          gnt_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic knobs_idle();
    s_valid = '0; s_rready = '0; s_arready = 1'b0; s_rv = 1'b0; s_rlast = 1'b0;
    s_rid = '0; s_rdata = '0; s_rresp = '0;
    for (int i = 0; i < N; i++) begin
      s_addr[i] = {$urandom, $urandom}; s_len[i] = 8'($urandom); s_size[i] = 3'($urandom);
    end
  endtask

  task automatic drive();
    rq_ar_valid = s_valid;
    rq_r_ready  = s_rready;
    for (int i = 0; i < N; i++) begin
      rq_ar_addr[64*i +: 64] = s_addr[i];
      rq_ar_len[8*i +: 8]    = s_len[i];
      rq_ar_size[3*i +: 3]   = s_size[i];
    end
    mem_resp          = '0;
    mem_resp.ar_ready = s_arready;
    mem_resp.r_valid  = s_rv;
    mem_resp.r.id     = s_rid;
    mem_resp.r.data   = s_rdata;
    mem_resp.r.resp   = s_rresp;
    mem_resp.r.last   = s_rlast;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_pend = 1'b0; m_w = 0;
    gnt_q.delete();
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int idx;
`ifdef IOMMU_RD_ARB_FIXPRIO_EN
      idx = k;
`else
      idx = (m_ptr + k) % N;
`endif
      if (s_valid[idx] && m_cnt[idx] < MAXO) return idx;
    end
    return -1;
  endfunction

  // One clock: apply knobs, check every output against the model, advance the model.
  task automatic step();
    int w, inc, dec;
    logic [N-1:0] e_rdy, e_rv;
    logic e_rr, e_err, e_busy;
    @(negedge clk);
    drive();
    #1;
    w = m_pend ? -1 : pick();
    e_rdy = '0;
    if (w >= 0) e_rdy[w] = 1'b1;
    e_busy = m_pend;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) e_busy = 1'b1;
    e_rv = '0; e_err = 1'b0; inc = -1; dec = -1;
    if (int'(s_rid) < N) begin
      e_rr = s_rready[s_rid];
      if (s_rv) begin
        e_rv[s_rid] = 1'b1;
        if (e_rr && s_rlast) dec = int'(s_rid);
      end
    end else begin
      e_rr  = 1'b1;
      e_err = s_rv;
    end
    if (m_pend && s_arready) inc = m_w;
    if (dec >= 0 && dec != inc && m_cnt[dec] == 0) e_err = 1'b1;

    chk("ar_ready", 64'(rq_ar_ready), 64'(e_rdy));
    chk("ar_valid", 64'(mem_req.ar_valid), 64'(m_pend));
    if (m_pend) begin
      chk("ar_id", 64'(mem_req.ar.id), 64'(m_w));
      chk("ar_addr", mem_req.ar.addr, m_addr);
      chk("ar_len", 64'(mem_req.ar.len), 64'(m_len));
      chk("ar_size", 64'(mem_req.ar.size), 64'(m_size));
      chk("ar_attr", 64'({mem_req.ar.burst, mem_req.ar.cache, mem_req.ar.prot}), 64'({2'b01, 4'b0010, 3'b000}));
    end
    chk("aw_w_b", 64'({mem_req.aw_valid, mem_req.w_valid, mem_req.b_ready}), 64'(3'b001));
    chk("r_valid", 64'(rq_r_valid), 64'(e_rv));
    chk("r_ready", 64'(mem_req.r_ready), 64'(e_rr));
    chk("err_id", 64'(err_id), 64'(e_err));
    chk("busy", 64'(busy), 64'(e_busy));
    if (s_rv) begin
      chk("r_data", rq_r_data, s_rdata);
      chk("r_resp_last", 64'({rq_r_resp, rq_r_last}), 64'({s_rresp, s_rlast}));
    end
    if (m_pend && s_arready) gnt_q.push_back(int'(mem_req.ar.id));

    if (inc >= 0 && inc != dec) m_cnt[inc]++;
    if (dec >= 0 && dec != inc && m_cnt[dec] > 0) m_cnt[dec]--;
    if (m_pend) begin
      if (s_arready) begin
        m_pend = 1'b0;
        m_ptr  = (m_w + 1) % N;
      end
    end else if (w >= 0) begin
      m_pend = 1'b1; m_w = w;
      m_addr = s_addr[w]; m_len = s_len[w]; m_size = s_size[w];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    knobs_idle();
    drive();
    rst = 1'b1;
    #1;
    chk("rst_outputs", 64'({rq_ar_ready, rq_r_valid, busy, err_id, mem_req.ar_valid}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int exp_g [4];
    int beat;
    rst = 1'b1;
    knobs_idle();
    drive();
    model_reset();
    do_reset();

    // Idle after reset
    repeat (3) step();
    chk("idle_data", 64'({rq_r_data, rq_r_resp, rq_r_last}), 64'(0));

    // Requesters 0 and 2 contend
    s_valid = 4'b0101; s_arready = 1'b1;
    repeat (8) step();
`ifdef IOMMU_RD_ARB_FIXPRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 2, 0, 2};
`endif
    chk("gnt_count", 64'(gnt_q.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("gnt_order%0d", i), 64'(gnt_q.size() > i ? gnt_q[i] : -1), 64'(exp_g[i]));
    do_reset();

    // Outstanding limit on requester 1
    s_valid = 4'b0010; s_arready = 1'b1;
    repeat (8) step();
    repeat (3) step();
    chk("limit_blocked", 64'(rq_ar_ready[1]), 64'(0));
    s_rv = 1'b1; s_rid = 4'd1; s_rlast = 1'b1; s_rready = 4'b0010;
    step();
    s_rv = 1'b0; s_rlast = 1'b0; s_rready = '0;
    step();
    chk("limit_regrant", 64'(rq_ar_ready), 64'(4'b0010));
    step();
    chk("limit_gnt_count", 64'(gnt_q.size()), 64'(5));
    do_reset();

    // 4-beat burst to requester 3 with toggling ready
    s_valid = 4'b1000; s_arready = 1'b1;
    step(); step();
    s_valid = '0;
    beat = 0;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      s_rv = 1'b1; s_rid = 4'd3; s_rlast = (beat == 3); s_rdata = {$urandom, $urandom};
      s_rresp = 2'($urandom);
      s_rready = 4'($urandom); s_rready[3] = c[0];
      step();
      if (s_rready[3]) beat++;
    end
    chk("burst_beats", 64'(beat), 64'(4));
    knobs_idle();
    step();
    chk("burst_busy_clear", 64'(busy), 64'(0));

    // Unmapped ID beat
    s_valid = 4'b0100; s_arready = 1'b1;
    step(); step();
    s_valid = '0;
    s_rv = 1'b1; s_rid = 4'd7; s_rlast = 1'b1; s_rready = '0;
    step();
    chk("err7_pulse", 64'({err_id, mem_req.r_ready}), 64'(2'b11));
    knobs_idle();
    step();
    chk("err7_clear_busy", 64'({err_id, busy}), 64'(2'b01));
    do_reset();

    // Stall in HOLD for 5 cycles, then asynchronous reset
    s_valid = 4'b0100; s_arready = 1'b0;
    step();
    repeat (5) step();
    @(negedge clk);
    #1;
    chk("stall_valid", 64'(mem_req.ar_valid), 64'(1));
    s_valid = '0; drive();
    rst = 1'b1;
    #1;
    chk("rst_arvalid", 64'({mem_req.ar_valid, busy}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    knobs_idle();
    model_reset();
    step();

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      s_valid   = 4'($urandom);
      s_arready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
        s_addr[i] = {$urandom, $urandom}; s_len[i] = 8'($urandom); s_size[i] = 3'($urandom);
      end
      s_rready = 4'($urandom);
      s_rv     = ($urandom % 3) == 0;
      s_rid    = (($urandom % 10) == 0) ? 4'(4 + $urandom % 12) : 4'($urandom % 4);
      s_rlast  = 1'($urandom);
      s_rdata  = {$urandom, $urandom};
      s_rresp  = 2'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
